// File: rtl/pipeline_memory_writeback.sv
// pipeline_memory_writeback: MEM/WB stage of the pipelined CPU.
// Issues the data-cache request for the instruction in MEM and stalls the pipe
// until dhit. If the pipe is held on the dhit cycle, the load data is parked in a
// buffer (HELD) so the access is never reissued. Selects the writeback value and
// registers it into the WB latch.
// Optional feature: define MEMWB_WATCHDOG_EN to build the stall watchdog that
// drives mem_timeout. Without it, mem_timeout is tied low.

package cpu_types_pkg;
  typedef enum logic [1:0] {
    PIPE_ENABLE = 2'd0,
    PIPE_NOP    = 2'd1,
    PIPE_STALL  = 2'd2
  } pipe_state_t;
endpackage

module pipeline_memory_writeback
  import cpu_types_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              dREN_mem,
  input  logic              dWEN_mem,
  input  logic              MemToReg_mem,
  input  logic              RegWrite_mem,
  input  logic              halt_mem,
  input  logic              jal_mem,
  input  logic [DATA_W-1:0] port_o_mem,
  input  logic [DATA_W-1:0] rdat2_mem,
  input  logic [DATA_W-1:0] pc4_mem,
  input  logic [4:0]        regWSEL_mem,
  input  pipe_state_t       mw_state,
  input  logic              dhit,
  input  logic [DATA_W-1:0] dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [DATA_W-1:0] dmemaddr,
  output logic [DATA_W-1:0] dmemstore,
  output logic              mem_stall,
  output logic              RegWrite_wb,
  output logic [4:0]        regWSEL_wb,
  output logic [DATA_W-1:0] wdat_wb,
  output logic              halt_wb,
  output logic              mem_timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HELD = 2'd2
  } mw_fsm_t;

  mw_fsm_t           state_p0;
  logic [DATA_W-1:0] ldbuf_p0;

  logic              memop;
  logic              held;
  logic              pipe_en;
  logic              pipe_nop;
  logic              wb_load;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] result;

  // Request side: the access is suppressed once it has completed and is parked
  assign memop     = dREN_mem | dWEN_mem;
  assign held      = (state_p0 == HELD);
  assign dmemREN   = dREN_mem & ~held;
  assign dmemWEN   = dWEN_mem & ~held;
  assign dmemaddr  = port_o_mem;
  assign dmemstore = rdat2_mem;
  assign mem_stall = (dmemREN | dmemWEN) & ~dhit;

  assign pipe_en   = (mw_state == PIPE_ENABLE);
  assign pipe_nop  = (mw_state == PIPE_NOP);
  assign wb_load   = pipe_en & ~mem_stall;

  // Writeback value: parked data while HELD, live cache data otherwise
  assign ld_data = held ? ldbuf_p0 : dmemload;
  assign result  = MemToReg_mem ? ld_data :
                   jal_mem      ? pc4_mem : port_o_mem;

  // Access FSM and load buffer; a NOP abandons whatever is pending, even on dhit
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_p0 <= IDLE;
      ldbuf_p0 <= '0;
    end else if (pipe_nop) begin
      state_p0 <= IDLE;
    end else begin
      case (state_p0)
        IDLE, WAIT: begin
          if (memop && !dhit) begin
            state_p0 <= WAIT;
          end else if (memop && dhit) begin
            if (pipe_en) begin
              state_p0 <= IDLE;
            end else begin
              state_p0 <= HELD;
              ldbuf_p0 <= dmemload;
            end
          end else begin
            state_p0 <= IDLE;
          end
        end
        HELD: begin
          if (pipe_en) state_p0 <= IDLE;
        end
        default: state_p0 <= IDLE;
      endcase
    end
  end

  // WB latch: cleared by NOP, loaded when the pipe advances and memory is done
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RegWrite_wb <= 1'b0;
      regWSEL_wb  <= '0;
      wdat_wb     <= '0;
    end else if (pipe_nop) begin
      RegWrite_wb <= 1'b0;
      regWSEL_wb  <= '0;
      wdat_wb     <= '0;
    end else if (wb_load) begin
      RegWrite_wb <= RegWrite_mem;
      regWSEL_wb  <= regWSEL_mem;
      wdat_wb     <= result;
    end
  end

  // Halt is sticky: once a halting instruction retires, only reset clears it
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      halt_wb <= 1'b0;
    end else if (wb_load && halt_mem && !pipe_nop) begin
      halt_wb <= 1'b1;
    end
  end

`ifdef MEMWB_WATCHDOG_EN
  logic [7:0] wd_cnt_p0;

  // Count consecutive stalled cycles; flag a memory that never answers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wd_cnt_p0   <= '0;
      mem_timeout <= 1'b0;
    end else begin
      if (!mem_stall) begin
        wd_cnt_p0 <= '0;
      end else if (wd_cnt_p0 != 8'hFF) begin
        wd_cnt_p0 <= wd_cnt_p0 + 8'd1;
      end
      if (mem_stall && (wd_cnt_p0 >= 8'd254)) mem_timeout <= 1'b1;
    end
  end
`else
  assign mem_timeout = 1'b0;
`endif

endmodule

// File: doc/pipeline_memory_writeback.md
PIPELINE_MEMORY_WRITEBACK -- requirements
Module: pipeline_memory_writeback

Interface
REQ-001 The block SHALL have ports: CLK  in  1  rising-edge clock; RST  in  1  asynchronous active-high reset.
REQ-002 The block SHALL have EX/MEM-side inputs:
  - dREN_mem, dWEN_mem, MemToReg_mem, RegWrite_mem, halt_mem, jal_mem  in  1 each  control bits of the instruction in MEM.
  - port_o_mem  in  32  ALU result / data address.
  - rdat2_mem  in  32  store data.
  - pc4_mem  in  32  link value.
  - regWSEL_mem  in  5  destination register.
REQ-003 The block SHALL have control input mw_state  in  pipe_state_t (cpu_types_pkg)  PIPE_ENABLE / PIPE_NOP / other = hold.
REQ-004 The block SHALL have data-cache ports:
  - dhit  in  1  access done this cycle.
  - dmemload  in  32  load data.
  - dmemREN, dmemWEN  out  1 each.
  - dmemaddr, dmemstore  out  32 each.
REQ-005 The block SHALL have outputs:
  - mem_stall  out  1  to hazard unit.
  - RegWrite_wb  out  1.
  - regWSEL_wb  out  5.
  - wdat_wb  out  32.
  - halt_wb  out  1.

Function
REQ-006 The FSM SHALL have states IDLE, WAIT and HELD, with reset state IDLE.
REQ-007 The block SHALL define memop = dREN_mem | dWEN_mem.
REQ-008 In IDLE and WAIT, dmemREN SHALL equal dREN_mem and dmemWEN SHALL equal dWEN_mem; in HELD both SHALL be 0.
REQ-009 dmemaddr SHALL equal port_o_mem and dmemstore SHALL equal rdat2_mem, combinationally.
REQ-010 mem_stall SHALL equal (dmemREN | dmemWEN) & ~dhit, combinationally, with zero added latency.
REQ-011 The result SHALL be:
  - buffered load data if MemToReg_mem;
  - else pc4_mem if jal_mem;
  - else port_o_mem.
  Buffered load data is dmemload on the dhit cycle, or the 32-bit load buffer when in HELD.
REQ-012 FSM transitions from IDLE or WAIT:
  - memop & ~dhit -> WAIT.
  - dhit & mw_state==PIPE_ENABLE -> IDLE, and the WB register loads.
  - dhit & mw_state is a hold value -> HELD, and the load buffer captures dmemload.
  - ~memop -> IDLE.
REQ-013 FSM transitions from HELD:
  - mw_state==PIPE_ENABLE -> WB register loads from the buffer, then IDLE.
  - Hold -> remain in HELD; the request SHALL NOT be reissued.
REQ-014 The WB register (RegWrite_wb, regWSEL_wb, wdat_wb) SHALL load on a rising edge only when mw_state==PIPE_ENABLE and mem_stall==0.
REQ-015 When mw_state==PIPE_ENABLE and mem_stall==1, the WB register SHALL hold its value.
REQ-016 When mw_state==PIPE_NOP, the WB register SHALL clear to 0 on the next edge.
REQ-017 When mw_state==PIPE_NOP, the FSM SHALL go to IDLE and any pending request SHALL be abandoned.
REQ-018 PIPE_NOP SHALL take priority over dhit in the same cycle.
REQ-019 A store SHALL complete exactly once per instruction; HELD SHALL guarantee no duplicate write.
REQ-020 halt_wb SHALL set when a WB load occurs with halt_mem=1, and SHALL stay set until reset; PIPE_NOP SHALL NOT clear it.
REQ-021 Latency: a non-memory instruction SHALL reach WB outputs 1 cycle after PIPE_ENABLE; a memory instruction SHALL reach WB outputs on the edge following dhit plus PIPE_ENABLE.

Reset
REQ-022 While RST=1, all registered outputs, the load buffer and the watchdog SHALL be 0, and the FSM SHALL be IDLE.
REQ-023 Reset SHALL take effect asynchronously, including mid-WAIT or mid-HELD.
REQ-024 After RST deasserts, the block SHALL issue no request until IDLE sees memop.

Configuration
REQ-025 With MEMWB_WATCHDOG_EN defined, the block SHALL provide:
  - an 8-bit counter that increments each cycle mem_stall=1 and clears when mem_stall=0;
  - output mem_timeout (1 bit, sticky until reset), which sets when the counter reaches 255.
REQ-026 Without MEMWB_WATCHDOG_EN, mem_timeout SHALL be tied to 0 and no counter logic SHALL exist.

Verification
REQ-027 Add, port_o_mem=0x0000_0010, regWSEL=3, RegWrite=1, PIPE_ENABLE -> next cycle wdat_wb=0x10, regWSEL_wb=3, no dmemREN/dmemWEN.
REQ-028 Load, addr 0x100, dhit after 3 cycles, dmemload=0xDEADBEEF -> mem_stall=1 for 3 cycles, then wdat_wb=0xDEADBEEF one edge later.
REQ-029 Store with dhit while mw_state=hold for 4 cycles, then PIPE_ENABLE -> dmemWEN high exactly until dhit (one write), state HELD for 4 cycles, then WB loads.
REQ-030 Load pending in WAIT and PIPE_NOP asserted -> dmemREN=0 next cycle, WB outputs=0, FSM IDLE; RST pulsed mid-WAIT -> outputs 0 immediately.
REQ-031 jal_mem=1, pc4_mem=0x44, regWSEL=31 -> wdat_wb=0x44; then halt_mem=1 with PIPE_ENABLE -> halt_wb=1, stays 1 across a subsequent PIPE_NOP.
REQ-032 With MEMWB_WATCHDOG_EN defined, hold dhit=0 under a load for 255 cycles -> mem_timeout=1 and it stays 1 after dhit arrives.
